// File: rtl/gpio_count_monitor.sv
// rtl/gpio_count_monitor.sv - GPIO down-counter monitor: sync, glitch filter, sequence check, stats, timeout
module gpio_count_monitor #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000,
    parameter int CNT_W         = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] GPIO_4bits,
    input  logic             Enable,
    input  logic             clear_stats,
    output logic             step_valid,
    output logic [WIDTH-1:0] step_value,
    output logic             seq_error,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] wrap_count,
    output logic [CNT_W-1:0] error_count
);

    localparam int SC_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    localparam logic [SC_W-1:0]  STABLE_MAX = SC_W'(STABLE_CYCLES);
    localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] VALUE_MAX  = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] STAT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  sync1;
    logic [WIDTH-1:0]  s;
    logic [WIDTH-1:0]  cand;
    logic [SC_W-1:0]   stab;
    logic [TO_W-1:0]   ivl;

    logic              accept;
    logic              match;
    logic              wrap_hit;
    logic              err_hit;
    logic [WIDTH-1:0]  expected;

    // Two-flop synchroniser for the asynchronous GPIO pins
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= GPIO_4bits;
            s     <= sync1;
        end
    end

    // Stability filter: candidate follows s, counter measures how long it has been steady
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cand <= '0;
            stab <= '0;
        end else if (!Enable) begin
            cand <= '0;
            stab <= '0;
        end else if (s != cand) begin
            cand <= s;
            stab <= SC_W'(1);
        end else if (stab != STABLE_MAX) begin
            stab <= stab + SC_W'(1);
        end
    end

    // ACQUIRE accepts any settled value; TRACK only accepts a change from step_value
    always_comb begin
        expected = step_value - WIDTH'(1);
        match    = (cand == expected);
        accept   = Enable && (stab == STABLE_MAX) &&
                   ((state == ACQUIRE) || ((state == TRACK) && (cand != step_value)));
        wrap_hit = accept && (state == TRACK) && match &&
                   (step_value == '0) && (cand == VALUE_MAX);
        err_hit  = accept && (state == TRACK) && !match;
    end

    // Main FSM with registered step, lock and timeout outputs
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            step_valid <= 1'b0;
            step_value <= '0;
            seq_error  <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            ivl        <= '0;
        end else begin
            step_valid <= 1'b0;
            seq_error  <= 1'b0;
            if (!Enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                        ivl    <= '0;
                    end
                    ACQUIRE: begin
                        locked <= 1'b0;
                        if (accept) begin
                            step_valid <= 1'b1;
                            step_value <= cand;
                            timeout    <= 1'b0;
                            ivl        <= '0;
                            state      <= TRACK;
                        end else if (ivl != TO_MAX) begin
                            ivl <= ivl + TO_W'(1);
                        end
                    end
                    TRACK: begin
                        if (accept) begin
                            step_valid <= 1'b1;
                            step_value <= cand;
                            seq_error  <= !match;
                            locked     <= match;
                            timeout    <= 1'b0;
                            ivl        <= '0;
                        end else if (ivl != TO_MAX) begin
                            ivl <= ivl + TO_W'(1);
                            if (ivl == TO_LAST) begin
                                timeout <= 1'b1;
                                locked  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Saturating statistics; a clear wins over a simultaneous increment
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrap_count  <= '0;
            error_count <= '0;
        end else if (clear_stats) begin
            wrap_count  <= '0;
            error_count <= '0;
        end else begin
            if (wrap_hit && (wrap_count != STAT_MAX)) begin
                wrap_count <= wrap_count + CNT_W'(1);
            end
            if (err_hit && (error_count != STAT_MAX)) begin
                error_count <= error_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gpio_count_monitor.sv
// tb/tb_gpio_count_monitor.sv - scoreboard bench for gpio_count_monitor
module tb_gpio_count_monitor;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] GPIO_4bits;
    logic       Enable;
    logic       clear_stats;
    logic       step_valid;
    logic [3:0] step_value;
    logic       seq_error;
    logic       locked;
    logic       timeout;
    logic [7:0] wrap_count;
    logic [7:0] error_count;

    gpio_count_monitor #(
        .WIDTH(4), .STABLE_CYCLES(4), .TIMEOUT(1000), .CNT_W(8)
    ) dut (
        .Clock(Clock), .Reset(Reset), .GPIO_4bits(GPIO_4bits), .Enable(Enable),
        .clear_stats(clear_stats), .step_valid(step_valid), .step_value(step_value),
        .seq_error(seq_error), .locked(locked), .timeout(timeout),
        .wrap_count(wrap_count), .error_count(error_count)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  val;
        logic        err;
        logic        lock;
        logic        tmo;
    } ev_t;

    ev_t  exp_q[$];
    ev_t  obs_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [3:0] m_sv;
    logic       m_first;
    logic [7:0] m_err;
    logic [7:0] m_wrap;
    int         last_cyc;

    always @(posedge Clock) cyc <= cyc + 1;

    // Record every step pulse with the cycle it appeared in
    always @(negedge Clock) begin
        if (!Reset && step_valid) begin
            ev_t o;
            o.cyc  = 32'(cyc);
            o.val  = step_value;
            o.err  = seq_error;
            o.lock = locked;
            o.tmo  = timeout;
            obs_q.push_back(o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a value now (caller is on a negedge) and predict its step event
    task automatic drive(input logic [3:0] v, input int hold);
        ev_t e;
        GPIO_4bits = v;
        e.cyc = 32'(cyc + 7);
        e.val = v;
        e.tmo = 1'b0;
        if (m_first) begin
            e.err   = 1'b0;
            e.lock  = 1'b0;
            m_first = 1'b0;
        end else begin
            e.err  = (v != 4'(m_sv - 4'd1));
            e.lock = !e.err;
            if (e.err && m_err != 8'hff) m_err = m_err + 8'd1;
            if (!e.err && m_sv == 4'd0 && v == 4'hf && m_wrap != 8'hff) m_wrap = m_wrap + 8'd1;
        end
        m_sv = v;
        last_cyc = cyc + 7;
        exp_q.push_back(e);
        repeat (hold) @(negedge Clock);
    endtask

    task automatic check_steps();
        int budget;
        ev_t e;
        ev_t o;
        budget = 40;
        while (obs_q.size() < exp_q.size() && budget > 0) begin
            @(negedge Clock);
            budget--;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) o = obs_q.pop_front();
            else o = '0;
            chk("step_event", 64'(o), 64'(e));
        end
        chk("extra_steps", 64'(obs_q.size()), 64'(0));
        obs_q.delete();
    endtask

    initial begin
        int a_cyc;
        Reset = 1'b1;
        Enable = 1'b1;
        GPIO_4bits = 4'd0;
        clear_stats = 1'b0;
        m_sv = 4'd0;
        m_first = 1'b1;
        m_err = 8'd0;
        m_wrap = 8'd0;
        last_cyc = 0;

        #50;
        chk("reset_step_value", 64'(step_value), 64'(0));
        chk("reset_step_valid", 64'(step_valid), 64'(0));
        chk("reset_locked", 64'(locked), 64'(0));
        chk("reset_timeout", 64'(timeout), 64'(0));
        chk("reset_wrap", 64'(wrap_count), 64'(0));
        chk("reset_error", 64'(error_count), 64'(0));

        repeat (5) @(negedge Clock);
        Reset = 1'b0;
        drive(4'd9, 20);
        drive(4'd8, 20);
        drive(4'd7, 20);
        check_steps();
        chk("error_after_987", 64'(error_count), 64'(m_err));

        for (int k = 0; k < 18; k++) drive(4'(6 - k), 10);
        check_steps();
        chk("wrap_once", 64'(wrap_count), 64'(m_wrap));
        chk("wrap_value", 64'(m_wrap), 64'(1));
        chk("locked_after_wrap", 64'(locked), 64'(1));

        drive(4'd3, 20);
        chk("error_one", 64'(error_count), 64'(m_err));
        drive(4'd2, 20);
        check_steps();

        drive(4'd5, 20);
        GPIO_4bits = 4'd9;
        repeat (2) @(negedge Clock);
        GPIO_4bits = 4'd5;
        repeat (20) @(negedge Clock);
        check_steps();
        chk("glitch_hold", 64'(step_value), 64'(5));

        drive(4'd4, 20);
        a_cyc = last_cyc;
        check_steps();
        while (cyc < a_cyc + 999) @(negedge Clock);
        chk("timeout_before", 64'(timeout), 64'(0));
        chk("locked_before_to", 64'(locked), 64'(1));
        @(negedge Clock);
        chk("timeout_at", 64'(timeout), 64'(1));
        chk("locked_at_to", 64'(locked), 64'(0));
        drive(4'd3, 20);
        check_steps();

        while (m_err != 8'hff) drive((m_sv == 4'd3) ? 4'd10 : 4'd3, 8);
        drive((m_sv == 4'd3) ? 4'd10 : 4'd3, 8);
        check_steps();
        chk("error_saturate", 64'(error_count), 64'(255));

        drive(4'd0, 10);
        chk("wrap_before_clear", 64'(wrap_count), 64'(1));
        drive(4'd15, 6);
        clear_stats = 1'b1;
        @(negedge Clock);
        clear_stats = 1'b0;
        repeat (5) @(negedge Clock);
        m_wrap = 8'd0;
        m_err = 8'd0;
        check_steps();
        chk("clear_wrap", 64'(wrap_count), 64'(m_wrap));
        chk("clear_error", 64'(error_count), 64'(m_err));
        chk("pre_reset_value", 64'(step_value), 64'(15));
        chk("pre_reset_locked", 64'(locked), 64'(1));

        GPIO_4bits = 4'd14;
        repeat (2) @(negedge Clock);
        #2 Reset = 1'b1;
        #1;
        chk("async_step_value", 64'(step_value), 64'(0));
        chk("async_locked", 64'(locked), 64'(0));
        chk("async_step_valid", 64'(step_valid), 64'(0));
        chk("async_timeout", 64'(timeout), 64'(0));
        repeat (3) @(negedge Clock);
        chk("no_stray_steps", 64'(obs_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
